// File: rtl/turret_fire_control.sv
// Turret fire-control sequencer: track lock, IFF interrogation, arming and engagement.
// Optional macro TFC_BURST_LIMIT_EN caps rounds per engagement at BURST_ROUNDS.
module turret_fire_control #(
    parameter int LOCK_CYCLES  = 3,
    parameter int IFF_TIMEOUT  = 8,
    parameter int BURST_ROUNDS = 5
) (
    input  logic       sysclk,
    input  logic       reboot,
    input  logic       track_present,
    input  logic       iff_valid,
    input  logic       iff_friend,
    input  logic       op_fire,
    input  logic       op_auto,
    input  logic       gun_fire_trigger,
    input  logic       gun_alert,
    output logic       iff_req,
    output logic       target_locked,
    output logic       is_enemy,
    output logic       fire_command,
    output logic       firing_mode,
    output logic [2:0] fcu_state,
    output logic [7:0] rounds_fired,
    output logic       engage_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACQUIRE = 3'd1,
        S_IFF     = 3'd2,
        S_FRIEND  = 3'd3,
        S_ARMED   = 3'd4,
        S_ENGAGE  = 3'd5,
        S_HOLD    = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    // Counters are 8 bits wide, so every threshold must fit in that range.
    if (LOCK_CYCLES < 2 || LOCK_CYCLES > 255) begin : g_bad_lock
        $error("LOCK_CYCLES must be in 2..255");
    end
    if (IFF_TIMEOUT < 1 || IFF_TIMEOUT > 255) begin : g_bad_iff
        $error("IFF_TIMEOUT must be in 1..255");
    end
    if (BURST_ROUNDS < 1 || BURST_ROUNDS > 255) begin : g_bad_burst
        $error("BURST_ROUNDS must be in 1..255");
    end

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);
    localparam logic [7:0] IFF_LAST  = 8'(IFF_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [7:0] iff_cnt_q, iff_cnt_d;
    logic [7:0] rounds_q, rounds_d;
    logic       mode_q, mode_d;
    logic       trig_q;
    logic       done_q;
    logic       trig_rise;
    logic       burst_hit;

    assign trig_rise = gun_fire_trigger & ~trig_q;

`ifdef TFC_BURST_LIMIT_EN
    assign burst_hit = (rounds_q >= 8'(BURST_ROUNDS));
`else
    assign burst_hit = 1'b0;
`endif

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        iff_cnt_d  = iff_cnt_q;
        rounds_d   = rounds_q;
        mode_d     = mode_q;

        case (state_q)
            S_IDLE: begin
                if (track_present) begin
                    state_d    = S_ACQUIRE;
                    lock_cnt_d = 8'd1;
                end
            end
            S_ACQUIRE: begin
                if (!track_present) begin
                    state_d    = S_IDLE;
                    lock_cnt_d = 8'd0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = S_IFF;
                    lock_cnt_d = 8'd0;
                    iff_cnt_d  = 8'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            S_IFF: begin
                if (!track_present) begin
                    state_d = S_IDLE;
                end else if (iff_valid) begin
                    state_d = iff_friend ? S_FRIEND : S_ARMED;
                end else if (iff_cnt_q == IFF_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    iff_cnt_d = iff_cnt_q + 8'd1;
                end
            end
            S_FRIEND: begin
                if (!track_present) state_d = S_IDLE;
            end
            S_ARMED: begin
                if (!track_present) begin
                    state_d = S_IDLE;
                end else if (op_fire) begin
                    state_d  = S_ENGAGE;
                    mode_d   = op_auto;
                    rounds_d = 8'd0;
                end
            end
            S_ENGAGE: begin
                if (trig_rise && rounds_q != 8'hFF) rounds_d = rounds_q + 8'd1;
                if (!track_present)  state_d = S_IDLE;
                else if (gun_alert)  state_d = S_HOLD;
                else if (!op_fire)   state_d = S_ARMED;
                else if (burst_hit)  state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!track_present)              state_d = S_IDLE;
                else if (!gun_alert && !op_fire) state_d = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sysclk or posedge reboot) begin
        if (reboot) begin
            state_q    <= S_IDLE;
            lock_cnt_q <= 8'd0;
            iff_cnt_q  <= 8'd0;
            rounds_q   <= 8'd0;
            mode_q     <= 1'b0;
            trig_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            iff_cnt_q  <= iff_cnt_d;
            rounds_q   <= rounds_d;
            mode_q     <= mode_d;
            trig_q     <= gun_fire_trigger;
            done_q     <= (state_q == S_ENGAGE) && (state_d != S_ENGAGE);
        end
    end

    // Gun-facing flags are pure decodes of the state register, so fire implies locked and enemy.
    assign iff_req       = (state_q == S_IFF);
    assign target_locked = (state_q == S_IFF)    || (state_q == S_FRIEND) ||
                           (state_q == S_ARMED)  || (state_q == S_ENGAGE) ||
                           (state_q == S_HOLD);
    assign is_enemy      = (state_q == S_ARMED)  || (state_q == S_ENGAGE) ||
                           (state_q == S_HOLD);
    assign fire_command  = (state_q == S_ENGAGE);
    assign firing_mode   = mode_q;
    assign fcu_state     = state_q;
    assign rounds_fired  = rounds_q;
    assign engage_done   = done_q;

endmodule
